// File: rtl/lidar_frame_rx_if.sv
// Output-side bundle of the AGV lidar frame receiver: serial input plus the parallel frame result.
// The receiver uses the master modport; the consumer (control logic or bench) uses slave.
interface lidar_frame_rx_if #(
  parameter int unsigned PAYLOAD_BYTES = 6
);
  logic                       rxd;
  logic [PAYLOAD_BYTES*8-1:0] frame_data;
  logic                       frame_valid;
  logic                       frame_err;
  logic                       rx_busy;

  modport master (
    input  rxd,
    output frame_data,
    output frame_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rxd,
    input  frame_data,
    input  frame_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/lidar_frame_rx.sv
// 8N1 UART receiver that hunts for a two-byte header and then assembles a
// fixed-length payload, presenting it in parallel with a one-cycle strobe.
module lidar_frame_rx #(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned PAYLOAD_BYTES = 6,
  parameter logic [7:0]  HDR0          = 8'h55,
  parameter logic [7:0]  HDR1          = 8'hAA
) (
  input logic            clk,
  input logic            reset_n,
  lidar_frame_rx_if.master bus
);

  localparam int unsigned FRAME_W = PAYLOAD_BYTES * 8;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BCNT_W  = $clog2(PAYLOAD_BYTES + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_e;
  typedef enum logic [1:0] {FR_HUNT0, FR_HUNT1, FR_PAYLOAD} frame_state_e;

  logic rxMeta_q, rxs_q, rxsPrev_q;

  bit_state_e       bitState_q, bitState_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byteValid;
  logic             stopErr;

  frame_state_e      frState_q, frState_d;
  logic [BCNT_W-1:0] byteCnt_q, byteCnt_d;
  logic [FRAME_W-1:0] assembly_q, assembly_d;
  logic [FRAME_W-1:0] frameData_q, frameData_d;
  logic               frameValid_q, frameValid_d;

  // Idle-high synchroniser; rxsPrev_q gives the falling-edge reference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxMeta_q  <= 1'b1;
      rxs_q     <= 1'b1;
      rxsPrev_q <= 1'b1;
    end else begin
      rxMeta_q  <= bus.rxd;
      rxs_q     <= rxMeta_q;
      rxsPrev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitState_q <= BIT_IDLE;
      cycleCnt_q <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
    end else begin
      bitState_q <= bitState_d;
      cycleCnt_q <= cycleCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    bitState_d = bitState_q;
    cycleCnt_d = cycleCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    byteValid  = 1'b0;
    stopErr    = 1'b0;
    unique case (bitState_q)
      BIT_IDLE: begin
        if (rxsPrev_q && !rxs_q) begin
          bitState_d = BIT_START;
          cycleCnt_d = '0;
        end
      end
      BIT_START: begin
        if (cycleCnt_q == HALF_LAST) begin
          cycleCnt_d = '0;
          bitIdx_d   = '0;
          bitState_d = rxs_q ? BIT_IDLE : BIT_DATA;
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end
      BIT_DATA: begin
        if (cycleCnt_q == BIT_LAST) begin
          cycleCnt_d = '0;
          shift_d    = {rxs_q, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            bitState_d = BIT_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end
      BIT_STOP: begin
        // Leaving at mid-stop lets a start bit that follows with no idle gap be caught.
        if (cycleCnt_q == BIT_LAST) begin
          cycleCnt_d = '0;
          byteValid  = rxs_q;
          stopErr    = !rxs_q;
          bitState_d = BIT_IDLE;
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end
      default: bitState_d = BIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frState_q    <= FR_HUNT0;
      byteCnt_q    <= '0;
      assembly_q   <= '0;
      frameData_q  <= '0;
      frameValid_q <= 1'b0;
    end else begin
      frState_q    <= frState_d;
      byteCnt_q    <= byteCnt_d;
      assembly_q   <= assembly_d;
      frameData_q  <= frameData_d;
      frameValid_q <= frameValid_d;
    end
  end

  always_comb begin
    frState_d    = frState_q;
    byteCnt_d    = byteCnt_q;
    assembly_d   = assembly_q;
    frameData_d  = frameData_q;
    frameValid_d = 1'b0;
    if (stopErr) begin
      frState_d = FR_HUNT0;
      byteCnt_d = '0;
    end else if (byteValid) begin
      unique case (frState_q)
        FR_HUNT0: begin
          if (shift_q == HDR0) frState_d = FR_HUNT1;
        end
        FR_HUNT1: begin
          // A repeated HDR0 keeps the hunt armed so "55 55 AA" still locks.
          if (shift_q == HDR1) begin
            frState_d = FR_PAYLOAD;
            byteCnt_d = '0;
          end else if (shift_q != HDR0) begin
            frState_d = FR_HUNT0;
          end
        end
        FR_PAYLOAD: begin
          assembly_d = (assembly_q << 8) | FRAME_W'(shift_q);
          if (byteCnt_q == BYTE_LAST) begin
            frameData_d  = assembly_d;
            frameValid_d = 1'b1;
            frState_d    = FR_HUNT0;
            byteCnt_d    = '0;
          end else begin
            byteCnt_d = byteCnt_q + BCNT_W'(1);
          end
        end
        default: frState_d = FR_HUNT0;
      endcase
    end
  end

  assign bus.frame_data  = frameData_q;
  assign bus.frame_valid = frameValid_q;
  assign bus.frame_err   = stopErr;
  assign bus.rx_busy     = (bitState_q != BIT_IDLE);

endmodule

// File: tb/tb_lidar_frame_rx.sv
// Bench for lidar_frame_rx: table of directed byte streams, hand-written glitch
// and reset sequences, then a random byte stream checked against a stream-level model.
module tb_lidar_frame_rx;

  localparam int N     = 16;
  localparam int P     = 6;
  localparam int NRAND = 150;

  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           nBytes;
    logic [15:0]  badStop;
    int           gap;
    int           expValid;
    logic [47:0]  expA;
    logic [47:0]  expB;
    int           expErr;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lidar_frame_rx_if #(.PAYLOAD_BYTES(P)) bus ();

  lidar_frame_rx #(
    .CLKS_PER_BIT (N),
    .PAYLOAD_BYTES(P),
    .HDR0         (8'h55),
    .HDR1         (8'hAA)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int stopStartCyc = 0;
  int validCnt    = 0;
  int errCnt      = 0;
  logic [47:0] gotFrames[$];

  vec_t        vecs[4];
  logic [7:0]  hist[$];
  logic [47:0] expFrames[$];
  int          v0, e0, f0, expErrRand, hIdx, gap;
  logic [7:0]  b;
  logic        bad;
  logic [47:0] fr;
  logic [63:0] got;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every strobe is logged; latency is measured from the start of the last stop bit driven.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.frame_valid === 1'b1) begin
        validCnt++;
        gotFrames.push_back(bus.frame_data);
        checkOutput("valid_err_exclusive", 64'(bus.frame_err), 64'd0);
        checkOutput("valid_latency_in_window",
                    64'((cyc - stopStartCyc >= N / 2) && (cyc - stopStartCyc < N)), 64'd1);
      end
      if (bus.frame_err === 1'b1) errCnt++;
    end
  end

  task automatic sendByte(input logic [7:0] data, input logic stopOk, input int idle);
    bus.rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = data[i];
      repeat (N) @(negedge clk);
    end
    stopStartCyc = cyc;
    bus.rxd = stopOk;
    repeat (N) @(negedge clk);
    bus.rxd = 1'b1;
    repeat ((stopOk || idle >= N) ? idle : N) @(negedge clk);
  endtask

  task automatic applyStimulus(input int idx);
    for (int k = 0; k < vecs[idx].nBytes; k++) begin
      sendByte(vecs[idx].bytes[(vecs[idx].nBytes - 1 - k) * 8 +: 8],
               !vecs[idx].badStop[k], vecs[idx].gap);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_frame_data"},  64'(bus.frame_data),  64'd0);
    checkOutput({tag, "_frame_valid"}, 64'(bus.frame_valid), 64'd0);
    checkOutput({tag, "_frame_err"},   64'(bus.frame_err),   64'd0);
    checkOutput({tag, "_rx_busy"},     64'(bus.rx_busy),     64'd0);
  endtask

  initial begin
    vecs[0] = '{"clean", 128'h55AA_1234_0ABC_0001, 8, 16'h0000, 3, 1,
                48'h12340ABC0001, 48'h0, 0};
    vecs[1] = '{"hunt_resync", 128'h0055_55AA_0102_0304_0506, 10, 16'h0000, 5, 1,
                48'h010203040506, 48'h0, 0};
    vecs[2] = '{"framing_error", 128'h55AA_1122_33_55AA_6677_8899_AABB, 13, 16'h0010, 2, 1,
                48'h66778899AABB, 48'h0, 1};
    vecs[3] = '{"back_to_back", 128'h55AA_A1A2A3A4A5A6_55AA_B1B2B3B4B5B6, 16, 16'h0000, 0, 2,
                48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 0};

    reset_n = 1'b0;
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleOutputs("por");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      v0 = validCnt; e0 = errCnt; f0 = gotFrames.size();
      applyStimulus(i);
      repeat (2 * N) @(negedge clk);
      checkOutput({vecs[i].name, "_valid_count"}, 64'(validCnt - v0), 64'(vecs[i].expValid));
      checkOutput({vecs[i].name, "_err_count"},   64'(errCnt - e0),   64'(vecs[i].expErr));
      if (vecs[i].expValid >= 1) begin
        got = (gotFrames.size() > f0) ? {16'h0, gotFrames[f0]} : 64'hFFFF_FFFF_FFFF_FFFF;
        checkOutput({vecs[i].name, "_data_first"}, got, {16'h0, vecs[i].expA});
      end
      if (vecs[i].expValid >= 2) begin
        got = (gotFrames.size() > f0 + 1) ? {16'h0, gotFrames[f0 + 1]} : 64'hFFFF_FFFF_FFFF_FFFF;
        checkOutput({vecs[i].name, "_data_second"}, got, {16'h0, vecs[i].expB});
      end
      checkOutput({vecs[i].name, "_busy_idle"}, 64'(bus.rx_busy), 64'd0);
    end
    checkOutput("frame_data_held", 64'(bus.frame_data), {16'h0, 48'hB1B2B3B4B5B6});

    // Short low pulse: the receiver wakes up, rejects it at mid-start, and stays silent.
    v0 = validCnt; e0 = errCnt;
    bus.rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("glitch_busy_seen", 64'(bus.rx_busy), 64'd1);
    repeat (3 * N) @(negedge clk);
    checkOutput("glitch_busy_clear",  64'(bus.rx_busy),  64'd0);
    checkOutput("glitch_valid_count", 64'(validCnt - v0), 64'd0);
    checkOutput("glitch_err_count",   64'(errCnt - e0),   64'd0);

    // Reset in the middle of the third payload byte, then a fresh frame.
    sendByte(8'h55, 1'b1, 2);
    sendByte(8'hAA, 1'b1, 2);
    sendByte(8'h01, 1'b1, 2);
    sendByte(8'h02, 1'b1, 2);
    bus.rxd = 1'b0;
    repeat (N) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (N) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (N / 2) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("mid_reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    v0 = validCnt; e0 = errCnt; f0 = gotFrames.size();
    sendByte(8'h55, 1'b1, 1);
    sendByte(8'hAA, 1'b1, 1);
    for (int k = 0; k < P; k++) sendByte(8'hC1 + 8'(k), 1'b1, 1);
    repeat (2 * N) @(negedge clk);
    checkOutput("post_reset_valid_count", 64'(validCnt - v0), 64'd1);
    got = (gotFrames.size() > f0) ? {16'h0, gotFrames[f0]} : 64'hFFFF_FFFF_FFFF_FFFF;
    checkOutput("post_reset_data", got, {16'h0, 48'hC1C2C3C4C5C6});
    checkOutput("post_reset_err_count", 64'(errCnt - e0), 64'd0);

    // Random stream; the model locks on the earliest 55 AA pair since the last frame or error.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    hist.delete();
    expFrames.delete();
    expErrRand = 0;
    e0 = errCnt; f0 = gotFrames.size();
    for (int n = 0; n < NRAND; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: b = 8'h55;
        3, 4, 5: b = 8'hAA;
        default: b = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 24) == 0);
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      sendByte(b, !bad, gap);
      if (bad) begin
        expErrRand++;
        hist.delete();
      end else begin
        hist.push_back(b);
        hIdx = -1;
        for (int j = 0; j + 1 < hist.size(); j++)
          if (hIdx < 0 && hist[j] == 8'h55 && hist[j + 1] == 8'hAA) hIdx = j;
        if (hIdx >= 0 && hist.size() == hIdx + 2 + P) begin
          fr = '0;
          for (int j = 0; j < P; j++) fr = {fr[39:0], hist[hIdx + 2 + j]};
          expFrames.push_back(fr);
          hist.delete();
        end
      end
    end
    repeat (2 * N) @(negedge clk);
    checkOutput("rand_frame_count", 64'(gotFrames.size() - f0), 64'(expFrames.size()));
    for (int i = 0; i < expFrames.size(); i++) begin
      got = (gotFrames.size() > f0 + i) ? {16'h0, gotFrames[f0 + i]} : 64'hFFFF_FFFF_FFFF_FFFF;
      checkOutput($sformatf("rand_frame_%0d", i), got, {16'h0, expFrames[i]});
    end
    checkOutput("rand_err_count", 64'(errCnt - e0), 64'(expErrRand));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lidar_frame_rx.md
Name: lidar_frame_rx

Overview:
- UART receiver for the AGV link, the counterpart of the TxD frame transmitter.
- Deserialises 8N1 serial data and hunts for the 0x55 0xAA header.
- After the header, assembles the fixed-length payload of max_distance_angle, min_distance_angle and obs_alert, then presents it in parallel with a one-cycle valid strobe.
- Sits between the board RX pin and the AGV control logic.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- PAYLOAD_BYTES, 6, payload bytes following the 2-byte header.
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rxd  in  1  raw UART serial input, asynchronous to clk, idle high.
- frame_data  out  PAYLOAD_BYTES*8  last good payload. First received byte is in the MSBs: [47:32] max_distance_angle, [31:16] min_distance_angle, [15:0] obs_alert.
- frame_valid  out  1  one-cycle pulse when frame_data has just been updated.
- frame_err  out  1  one-cycle pulse on a stop-bit framing error.
- rx_busy  out  1  high while the bit FSM is not IDLE.

Behaviour:
- Clocking and reset:
  - One clock. reset_n is asynchronous and active-low.
  - Reset values: frame_data=0, frame_valid=0, frame_err=0, rx_busy=0. Synchroniser flops=1, both FSMs idle, all counters 0.
  - Reset mid-byte or mid-frame abandons all partial data.
- Input sync: rxd passes through a 2-flop synchroniser (rxs). Edge detection uses rxs and its previous value.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of rxs -> START, clear the cycle counter.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rxs.
    - rxs=0 -> DATA, bit index 0.
    - rxs=1 -> false start, back to IDLE with no error.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register, LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles (mid stop bit), sample rxs.
    - rxs=1: internal byte_valid for 1 cycle.
    - rxs=0: frame_err pulses in that same cycle and the byte is discarded.
    - Either way, return to IDLE in the same cycle, so a start bit immediately after mid-stop is caught (back-to-back bytes supported).
  - The cycle counter width is clog2(CLKS_PER_BIT); it never wraps inside a state.
- Frame FSM states: HUNT0, HUNT1, PAYLOAD. It advances only on byte_valid.
  - HUNT0: byte==HDR0 -> HUNT1; otherwise stay.
  - HUNT1:
    - byte==HDR1 -> PAYLOAD, byte count=0.
    - byte==HDR0 -> stay in HUNT1 (handles 55 55 AA).
    - any other byte -> HUNT0.
  - PAYLOAD: shift the byte into the assembly register (new byte enters at the LSB, earlier bytes move toward the MSB) and increment the count.
    - On byte number PAYLOAD_BYTES, on the next clk: frame_data <= assembly register, frame_valid=1 for one cycle, state -> HUNT0.
    - Header-valued bytes inside the payload are treated as data.
  - A framing error in any state forces HUNT0 and discards the partial payload. frame_data is not modified.
- Latency: frame_valid is asserted exactly 1 clk after the mid-stop-bit sample of the last payload byte. frame_data is stable from that cycle until the next frame_valid.
- frame_valid and frame_err are never high in the same cycle.

Test Plan (CLKS_PER_BIT=16):
- Clean frame: send 55 AA 12 34 0A BC 00 01 -> one frame_valid pulse, frame_data=48'h12340ABC0001, frame_err never high.
- Hunt/resync: send 00 55 55 AA 01 02 03 04 05 06 -> one frame_valid, frame_data=48'h010203040506.
- Framing error: send 55 AA 11 22, then a byte with stop bit=0, then a full clean frame with payload 66..BB -> frame_err pulses once, no frame_valid for the broken frame, then frame_data=48'h66778899AABB.
- Glitch: 4-cycle low pulse on idle rxd -> no byte accepted, rx_busy returns to 0, no outputs pulse.
- Back-to-back frames with zero idle between stop and next start, payloads A and B -> two frame_valid pulses, frame_data=A then B.
- Reset: assert reset_n=0 during the 3rd payload byte, release, send a clean frame -> all outputs 0 during reset, then exactly one frame_valid with the new payload.
